// File: rtl/py_sched_pkg.sv
// Shared types and constants for the payload-phase sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the state encoding, rate selector, phase lengths and small decode helpers.
package py_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GUARD = 3'd1,
        ST_SYNC  = 3'd2,
        ST_PYLD  = 3'd3,
        ST_TAIL  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        RATE_BR    = 2'd0,
        RATE_DQPSK = 2'd1,
        RATE_8DPSK = 2'd2
    } rate_t;

    localparam int DIV_BR     = 6;
    localparam int DIV_DQPSK  = 3;
    localparam int DIV_8DPSK  = 2;
    localparam int GUARD_CLKS = 30;
    localparam int SYNC_SYMS  = 11;
    localparam int SYM_CLKS   = 6;
    localparam int SYNC_CLKS  = SYNC_SYMS * SYM_CLKS;

    // Terminal divider count for a rate; the strobe fires on this value.
    function automatic logic [2:0] div_last(input rate_t rate);
        logic [2:0] last;
        last = 3'(DIV_BR - 1);
        case (rate)
            RATE_DQPSK: last = 3'(DIV_DQPSK - 1);
            RATE_8DPSK: last = 3'(DIV_8DPSK - 1);
            default:    last = 3'(DIV_BR - 1);
        endcase
        return last;
    endfunction

    // States in which the payload strobe runs.
    function automatic logic is_active(input seq_state_t s);
        return (s == ST_PYLD) || (s == ST_TAIL) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/py_strobe_gen.sv
// Symbol-rate divider and strobe decode for the payload phase.
// Latency: strobe is combinational from the registered divider. Backpressure: none.
// Ports: clk_6M/rstz clock+reset, clear forces the divider to 0, enable lets it count,
// rate selects the period, strobe is high when the divider sits on its terminal count.
module py_strobe_gen
    import py_sched_pkg::*;
(
    input  logic  clk_6M,
    input  logic  rstz,
    input  logic  clear,
    input  logic  enable,
    input  rate_t rate,
    output logic  strobe
);

    logic [2:0] div;
    logic [2:0] last;

    assign last = div_last(rate);

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            div <= 3'd0;
        end else if (clear) begin
            div <= 3'd0;
        end else if (enable) begin
            div <= (div == last) ? 3'd0 : div + 3'd1;
        end
    end

    assign strobe = enable && (div == last);

endmodule

// File: rtl/py_sched.sv
// Payload-phase sequencer: EDR guard/sync timing, payload strobe, tail/drain, completion.
// Latency: start_p -> py_st_p 1 cycle (BR) or 97 cycles (EDR); end pulse -> state change 1 cycle.
// Backpressure: none; the link controller may only abort. Watchdog build: PY_SCHED_WDOG_EN.
// Ports: start_p/abort_p control, mode bits and pylenbit sampled with start_p, end pulses from
// the bit processor; outputs py_st_p, py_datvalid_p, dec_py_endp_d1, seq_state/busy/done, wdog_err.
module py_sched
    import py_sched_pkg::*;
`ifdef PY_SCHED_WDOG_EN
#(
    parameter logic [13:0] WDOG_LIMIT = 14'd9000
)
`endif
(
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        start_p,
    input  logic        tx_mode,
    input  logic        packet_BRmode,
    input  logic        packet_DPSK,
    input  logic [12:0] pylenbit,
    input  logic        py_endp,
    input  logic        dec_py_endp,
    input  logic        edrtailer_endp,
    input  logic        abort_p,
    output logic        py_st_p,
    output logic        py_datvalid_p,
    output logic [1:0]  dec_py_endp_d1,
    output logic [2:0]  seq_state,
    output logic        seq_busy,
    output logic        seq_done_p,
    output logic        wdog_err
);

    seq_state_t state, state_nxt;
    logic       tx_q;
    rate_t      rate_q;
    logic       pyz_q;
    logic [6:0] cnt;
    logic       pend;
    logic       strobe;
    logic       accept;
    logic       py_st_nxt;
    logic       done_nxt;
    logic       wdog_trip;
    rate_t      rate_in;

    assign accept  = (state == ST_IDLE) && start_p && !abort_p;
    assign rate_in = packet_BRmode ? RATE_BR : (packet_DPSK ? RATE_DQPSK : RATE_8DPSK);

    py_strobe_gen u_strobe (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .clear  (!is_active(state_nxt)),
        .enable (is_active(state)),
        .rate   (rate_q),
        .strobe (strobe)
    );

    // State register plus the per-state clock counter used by GUARD and SYNC.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state <= ST_IDLE;
            cnt   <= 7'd0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? 7'd0 : cnt + 7'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_p) begin
                    if (!packet_BRmode)       state_nxt = ST_GUARD;
                    else if (pylenbit == '0)  state_nxt = ST_DONE;
                    else                      state_nxt = ST_PYLD;
                end
            end
            ST_GUARD: if (cnt == 7'(GUARD_CLKS - 1)) state_nxt = ST_SYNC;
            ST_SYNC:  if (cnt == 7'(SYNC_CLKS - 1))  state_nxt = pyz_q ? ST_DONE : ST_PYLD;
            ST_PYLD: begin
                if (tx_q ? py_endp : dec_py_endp)
                    state_nxt = (rate_q != RATE_BR) ? ST_TAIL : ST_DRAIN;
            end
            ST_TAIL:  if (edrtailer_endp) state_nxt = tx_q ? ST_DONE : ST_DRAIN;
            // Receive drains until the twice-delayed end has already been seen at a strobe.
            ST_DRAIN: if (tx_q || (strobe && dec_py_endp_d1[1])) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (wdog_trip) state_nxt = ST_IDLE;
        if (abort_p)   state_nxt = ST_IDLE;
    end

    always_comb begin
        py_st_nxt = (state_nxt == ST_PYLD) && (state != ST_PYLD);
        done_nxt  = (state == ST_DONE) && !abort_p;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            py_st_p    <= 1'b0;
            seq_done_p <= 1'b0;
            seq_busy   <= 1'b0;
            tx_q       <= 1'b0;
            rate_q     <= RATE_BR;
            pyz_q      <= 1'b0;
        end else begin
            py_st_p    <= py_st_nxt;
            seq_done_p <= done_nxt;
            seq_busy   <= (state_nxt != ST_IDLE);
            if (accept) begin
                tx_q   <= tx_mode;
                rate_q <= rate_in;
                pyz_q  <= (pylenbit == '0);
            end
        end
    end

    // The receive end is a one-shot per packet, so it stays latched in pend and
    // feeds bit 0 of the delay line on every strobe until the phase ends.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            pend           <= 1'b0;
            dec_py_endp_d1 <= 2'b00;
        end else if (!is_active(state_nxt)) begin
            pend           <= 1'b0;
            dec_py_endp_d1 <= 2'b00;
        end else begin
            if (dec_py_endp) pend <= 1'b1;
            if (strobe) dec_py_endp_d1 <= {dec_py_endp_d1[0], pend | dec_py_endp};
        end
    end

`ifdef PY_SCHED_WDOG_EN
    logic [13:0] wcnt;

    assign wdog_trip = strobe && (wcnt == WDOG_LIMIT - 14'd1);

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            wcnt     <= 14'd0;
            wdog_err <= 1'b0;
        end else begin
            if (!is_active(state_nxt)) wcnt <= 14'd0;
            else if (strobe)           wcnt <= wcnt + 14'd1;
            if (wdog_trip)             wdog_err <= 1'b1;
            else if (accept)           wdog_err <= 1'b0;
        end
    end
`else
    assign wdog_trip = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    assign seq_state     = state;
    assign py_datvalid_p = strobe;

endmodule

// File: tb/tb_py_sched.sv
// Directed bench for py_sched: reset, BR receive, 8DPSK transmit, zero length,
// abort, start/abort collision and the watchdog (or the hang without it).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_py_sched;
    import py_sched_pkg::*;

    logic        clk_6M = 1'b0;
    logic        rstz = 1'b0;
    logic        start_p = 1'b0;
    logic        tx_mode = 1'b0;
    logic        packet_BRmode = 1'b0;
    logic        packet_DPSK = 1'b0;
    logic [12:0] pylenbit = 13'd0;
    logic        py_endp = 1'b0;
    logic        dec_py_endp = 1'b0;
    logic        edrtailer_endp = 1'b0;
    logic        abort_p = 1'b0;
    logic        py_st_p;
    logic        py_datvalid_p;
    logic [1:0]  dec_py_endp_d1;
    logic [2:0]  seq_state;
    logic        seq_busy;
    logic        seq_done_p;
    logic        wdog_err;

    int errors = 0;
    int checks = 0;

    always #5 clk_6M = ~clk_6M;

`ifdef PY_SCHED_WDOG_EN
    py_sched #(.WDOG_LIMIT(14'd20)) dut (
`else
    py_sched dut (
`endif
        .clk_6M(clk_6M), .rstz(rstz), .start_p(start_p), .tx_mode(tx_mode),
        .packet_BRmode(packet_BRmode), .packet_DPSK(packet_DPSK), .pylenbit(pylenbit),
        .py_endp(py_endp), .dec_py_endp(dec_py_endp), .edrtailer_endp(edrtailer_endp),
        .abort_p(abort_p), .py_st_p(py_st_p), .py_datvalid_p(py_datvalid_p),
        .dec_py_endp_d1(dec_py_endp_d1), .seq_state(seq_state), .seq_busy(seq_busy),
        .seq_done_p(seq_done_p), .wdog_err(wdog_err)
    );

    task automatic cyc();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({py_st_p, py_datvalid_p, dec_py_endp_d1, seq_busy, seq_done_p, wdog_err} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {py_st_p, py_datvalid_p, dec_py_endp_d1, seq_busy, seq_done_p, wdog_err});
        end
        checks++;
        if (seq_state !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d required 0", seq_state);
        end
        cyc();
        rstz = 1'b1;
        cyc();
    endtask

    task automatic test_br_rx();
        tx_mode = 1'b0; packet_BRmode = 1'b1; packet_DPSK = 1'b0; pylenbit = 13'd240;
        start_p = 1'b1; cyc(); start_p = 1'b0;            // offset 1
        checks++;
        if (py_st_p !== 1'b1 || seq_state !== 3'd3) begin
            errors++; $display("FAIL br_start: py_st_p=%b state=%0d required 1/3", py_st_p, seq_state);
        end
        for (int k = 1; k <= 30; k++) begin
            checks++;
            if (py_datvalid_p !== (k % 6 == 0) || (k > 1 && py_st_p !== 1'b0)) begin
                errors++;
                $display("FAIL br_strobe@%0d: dv=%b st=%b required dv=%b st=0", k, py_datvalid_p, py_st_p, (k % 6 == 0));
            end
            cyc();
        end                                                // offset 31
        dec_py_endp = 1'b1; cyc(); dec_py_endp = 1'b0;     // offset 32
        checks++;
        if (seq_state !== 3'd5) begin
            errors++; $display("FAIL br_drain: state=%0d required 5", seq_state);
        end
        repeat (5) cyc();                                  // offset 37
        checks++;
        if (dec_py_endp_d1 !== 2'b01) begin
            errors++; $display("FAIL br_d1_first: got %b required 01", dec_py_endp_d1);
        end
        repeat (6) cyc();                                  // offset 43
        checks++;
        if (dec_py_endp_d1 !== 2'b11 || seq_state !== 3'd5) begin
            errors++; $display("FAIL br_d1_second: d1=%b state=%0d required 11/5", dec_py_endp_d1, seq_state);
        end
        repeat (6) cyc();                                  // offset 49
        checks++;
        if (seq_state !== 3'd6 || seq_done_p !== 1'b0) begin
            errors++; $display("FAIL br_done_state: state=%0d done=%b required 6/0", seq_state, seq_done_p);
        end
        cyc();                                             // offset 50
        checks++;
        if (seq_done_p !== 1'b1 || seq_state !== 3'd0) begin
            errors++; $display("FAIL br_done_pulse: done=%b state=%0d required 1/0", seq_done_p, seq_state);
        end
        cyc();
        checks++;
        if (seq_done_p !== 1'b0 || seq_busy !== 1'b0) begin
            errors++; $display("FAIL br_done_width: done=%b busy=%b required 0/0", seq_done_p, seq_busy);
        end
    endtask

    task automatic test_8dpsk_tx();
        tx_mode = 1'b1; packet_BRmode = 1'b0; packet_DPSK = 1'b0; pylenbit = 13'd100;
        start_p = 1'b1; cyc(); start_p = 1'b0;             // offset 1
        checks++;
        if (seq_state !== 3'd1 || seq_busy !== 1'b1) begin
            errors++; $display("FAIL edr_guard_entry: state=%0d busy=%b required 1/1", seq_state, seq_busy);
        end
        repeat (29) cyc();                                 // offset 30
        checks++;
        if (seq_state !== 3'd1) begin
            errors++; $display("FAIL edr_guard_end: state=%0d required 1", seq_state);
        end
        cyc();                                             // offset 31
        checks++;
        if (seq_state !== 3'd2) begin
            errors++; $display("FAIL edr_sync_entry: state=%0d required 2", seq_state);
        end
        repeat (65) cyc();                                 // offset 96
        checks++;
        if (seq_state !== 3'd2 || py_st_p !== 1'b0) begin
            errors++; $display("FAIL edr_sync_end: state=%0d st=%b required 2/0", seq_state, py_st_p);
        end
        cyc();                                             // offset 97
        checks++;
        if (seq_state !== 3'd3 || py_st_p !== 1'b1) begin
            errors++; $display("FAIL edr_py_st: state=%0d st=%b required 3/1", seq_state, py_st_p);
        end
        for (int k = 97; k <= 104; k++) begin
            checks++;
            if (py_datvalid_p !== (k % 2 == 0)) begin
                errors++; $display("FAIL edr_strobe@%0d: got %b required %b", k, py_datvalid_p, (k % 2 == 0));
            end
            cyc();
        end                                                // offset 105
        py_endp = 1'b1; cyc(); py_endp = 1'b0;             // offset 106
        for (int k = 106; k < 114; k++) begin
            checks++;
            if (seq_state !== 3'd4) begin
                errors++; $display("FAIL edr_tail_hold@%0d: state=%0d required 4", k, seq_state);
            end
            cyc();
        end                                                // offset 114
        edrtailer_endp = 1'b1; cyc(); edrtailer_endp = 1'b0;  // offset 115
        checks++;
        if (seq_state !== 3'd6 || seq_done_p !== 1'b0) begin
            errors++; $display("FAIL edr_done_state: state=%0d done=%b required 6/0", seq_state, seq_done_p);
        end
        cyc();
        checks++;
        if (seq_done_p !== 1'b1) begin
            errors++; $display("FAIL edr_done_pulse: got %b required 1", seq_done_p);
        end
        cyc();
    endtask

    task automatic test_zero_len();
        tx_mode = 1'b0; packet_BRmode = 1'b1; pylenbit = 13'd0;
        start_p = 1'b1; cyc(); start_p = 1'b0;             // offset 1
        checks++;
        if (seq_state !== 3'd6 || py_st_p !== 1'b0 || py_datvalid_p !== 1'b0 || seq_done_p !== 1'b0) begin
            errors++;
            $display("FAIL zero_t1: state=%0d st=%b dv=%b done=%b required 6/0/0/0", seq_state, py_st_p, py_datvalid_p, seq_done_p);
        end
        cyc();                                             // offset 2
        checks++;
        if (seq_done_p !== 1'b1 || py_st_p !== 1'b0 || seq_state !== 3'd0) begin
            errors++; $display("FAIL zero_t2: done=%b st=%b state=%0d required 1/0/0", seq_done_p, py_st_p, seq_state);
        end
        cyc();
    endtask

    task automatic test_abort_pyld();
        tx_mode = 1'b1; packet_BRmode = 1'b1; packet_DPSK = 1'b0; pylenbit = 13'd50;
        start_p = 1'b1; cyc(); start_p = 1'b0;             // offset 1
        cyc();                                             // offset 2
        dec_py_endp = 1'b1; cyc(); dec_py_endp = 1'b0;     // offset 3
        // Mode changes and a second start during PYLD must be ignored.
        tx_mode = 1'b0; packet_BRmode = 1'b0; start_p = 1'b1;
        cyc(); start_p = 1'b0;                             // offset 4
        checks++;
        if (py_st_p !== 1'b0 || seq_state !== 3'd3) begin
            errors++; $display("FAIL ignore_start: st=%b state=%0d required 0/3", py_st_p, seq_state);
        end
        for (int k = 4; k <= 12; k++) begin
            checks++;
            if (py_datvalid_p !== (k % 6 == 0)) begin
                errors++; $display("FAIL latched_rate@%0d: got %b required %b", k, py_datvalid_p, (k % 6 == 0));
            end
            cyc();
        end                                                // offset 13
        checks++;
        if (dec_py_endp_d1 !== 2'b11 || seq_state !== 3'd3) begin
            errors++; $display("FAIL pre_abort: d1=%b state=%0d required 11/3", dec_py_endp_d1, seq_state);
        end
        abort_p = 1'b1; cyc(); abort_p = 1'b0;             // offset 14
        checks++;
        if (seq_state !== 3'd0 || py_datvalid_p !== 1'b0 || dec_py_endp_d1 !== 2'b00 || seq_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: state=%0d dv=%b d1=%b busy=%b required 0/0/00/0", seq_state, py_datvalid_p, dec_py_endp_d1, seq_busy);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (seq_done_p !== 1'b0 || seq_state !== 3'd0) begin
                errors++; $display("FAIL abort_no_done@%0d: done=%b state=%0d required 0/0", k, seq_done_p, seq_state);
            end
            cyc();
        end
    endtask

    task automatic test_start_abort_idle();
        tx_mode = 1'b0; packet_BRmode = 1'b1; pylenbit = 13'd10;
        start_p = 1'b1; abort_p = 1'b1; cyc(); start_p = 1'b0; abort_p = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (seq_state !== 3'd0 || py_st_p !== 1'b0 || seq_busy !== 1'b0) begin
                errors++; $display("FAIL start_abort@%0d: state=%0d st=%b busy=%b required 0/0/0", k, seq_state, py_st_p, seq_busy);
            end
            cyc();
        end
    endtask

    task automatic test_watchdog();
        tx_mode = 1'b1; packet_BRmode = 1'b1; pylenbit = 13'd10;
        start_p = 1'b1; cyc(); start_p = 1'b0;             // offset 1
        repeat (119) cyc();                                // offset 120: 20th strobe
        checks++;
        if (py_datvalid_p !== 1'b1 || seq_state !== 3'd3 || wdog_err !== 1'b0) begin
            errors++; $display("FAIL wdog_pre: dv=%b state=%0d err=%b required 1/3/0", py_datvalid_p, seq_state, wdog_err);
        end
        cyc();                                             // offset 121
`ifdef PY_SCHED_WDOG_EN
        checks++;
        if (seq_state !== 3'd0 || wdog_err !== 1'b1 || seq_done_p !== 1'b0) begin
            errors++; $display("FAIL wdog_trip: state=%0d err=%b done=%b required 0/1/0", seq_state, wdog_err, seq_done_p);
        end
        cyc();
        checks++;
        if (wdog_err !== 1'b1 || seq_done_p !== 1'b0) begin
            errors++; $display("FAIL wdog_sticky: err=%b done=%b required 1/0", wdog_err, seq_done_p);
        end
        start_p = 1'b1; cyc(); start_p = 1'b0;
        checks++;
        if (wdog_err !== 1'b0 || seq_state !== 3'd3) begin
            errors++; $display("FAIL wdog_clear: err=%b state=%0d required 0/3", wdog_err, seq_state);
        end
`else
        checks++;
        if (seq_state !== 3'd3 || wdog_err !== 1'b0) begin
            errors++; $display("FAIL no_wdog_hang: state=%0d err=%b required 3/0", seq_state, wdog_err);
        end
`endif
        abort_p = 1'b1; cyc(); abort_p = 1'b0;
        checks++;
        if (seq_state !== 3'd0) begin
            errors++; $display("FAIL wdog_cleanup: state=%0d required 0", seq_state);
        end
    endtask

    initial begin
        test_reset();
        test_br_rx();
        test_8dpsk_tx();
        test_zero_len();
        test_abort_pyld();
        test_start_abort_idle();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
